daq_flash_arbiter: RTL and testbench
====================================

DAQ_FLASH_ARBITER -- requirements
Module: daq_flash_arbiter

Interface
REQ-001 SHALL have parameter CH_COUNT, default 4: number of sensor FIFO channels, range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: FIFO and flash data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 24: flash word-address width.
REQ-004 SHALL have parameter BURST_MAX, default 8: maximum beats per grant.
REQ-005 SHALL have parameters ADDR_BASE, default 0, and ADDR_LIMIT, default 2**ADDR_WIDTH-1: inclusive log address window.
REQ-006 SHALL have ports, as follows (one clock; reset asynchronous, active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begins an acquisition
- stop  in  1  pulse; requests end of the acquisition
- addr_clr  in  1  pulse; rewinds the address and clears mem_full
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- wrap_en  in  1  1 = wrap at ADDR_LIMIT, 0 = halt when the window is full
- burst_len  in  $clog2(BURST_MAX+1)  beats per grant; 0 is treated as 1; values above BURST_MAX are clamped to BURST_MAX
- fifo_empty  in  CH_COUNT  per-channel empty flag
- fifo_data  in  CH_COUNT*DATA_WIDTH  first-word-fall-through heads, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_rd  out  CH_COUNT  one-hot pop strobe
- flash_wr_valid  out  1  write request
- flash_wr_ready  in  1  flash accepts the write
- flash_wr_data  out  DATA_WIDTH  write data
- flash_wr_addr  out  ADDR_WIDTH  write word address
- flash_wr_ch  out  $clog2(CH_COUNT)  source channel tag
- busy  out  1  acquisition in progress
- done  out  1  one-cycle pulse when the acquisition ends
- wrap  out  1  one-cycle pulse on address wrap
- mem_full  out  1  sticky; window exhausted with wrap_en=0

Function
REQ-007 SHALL implement the FSM states IDLE, ARB, LOAD and XFER.
REQ-008 IDLE: busy=0; start -> ARB. If mem_full=1 on start, SHALL instead pulse done on the next cycle and remain in IDLE.
REQ-009 ARB: if the stop latch is set or all fifo_empty bits are 1 -> IDLE with a done pulse, and the stop latch clears; otherwise SHALL grant one non-empty channel, clear the beat counter and go to LOAD.
REQ-010 Round-robin grant SHALL search from (last_grant+1) mod CH_COUNT upward. Fixed-priority grant SHALL pick the lowest non-empty index. last_grant SHALL update on every grant in both modes.
REQ-011 LOAD: SHALL assert fifo_rd[grant] for exactly one cycle, register fifo_data[grant] into flash_wr_data, and go to XFER.
REQ-012 XFER: SHALL hold flash_wr_valid=1 with data, addr and ch stable until flash_wr_ready=1; a beat completes on the cycle where valid=1 and ready=1.
REQ-013 On beat completion, the address SHALL increment. At ADDR_LIMIT: if wrap_en=1, the address goes to ADDR_BASE and wrap pulses; if wrap_en=0, mem_full is set and the FSM goes to IDLE with a done pulse.
REQ-014 After a beat that does not fill the window, the FSM SHALL go to ARB if the beat count equals the effective burst_len, fifo_empty[grant]=1, or the stop latch is set; otherwise it SHALL go to LOAD.
REQ-015 The FIFO empty flag SHALL be treated as updating the cycle after a pop, so fifo_empty sampled in XFER reflects the pop issued in LOAD.
REQ-016 start SHALL be ignored while busy=1. stop SHALL be ignored in IDLE. A stop in any other state SHALL latch.
REQ-017 addr_clr SHALL act only in IDLE: the address becomes ADDR_BASE and mem_full clears. start and addr_clr in the same cycle SHALL apply addr_clr first.
REQ-018 No beat SHALL be lost or duplicated: every fifo_rd pulse SHALL produce exactly one accepted flash write.
REQ-019 fifo_rd SHALL never assert for an empty channel.

Reset
REQ-020 While rst=1, the block SHALL hold: state=IDLE, address=ADDR_BASE, last_grant=CH_COUNT-1, beat counter=0, stop latch=0. All outputs SHALL be 0, including mem_full.
REQ-021 Reset mid-XFER SHALL abandon the beat immediately; flash_wr_valid drops asynchronously.

Structure
REQ-022 Package daq_pkg SHALL hold the FSM state enum and the prio_mode encoding constants.
REQ-023 Grant selection SHALL live in sub-module daq_rr_arbiter: request vector, last_grant and mode in; one-hot grant and index out; purely combinational.

Verification
REQ-024 CH_COUNT=4, all FIFOs holding 2 words, round-robin, burst_len=1 -> grant order 0,1,2,3,0,1,2,3; addresses 0..7; done pulses after 8 beats.
REQ-025 Fixed priority, ch0 holding 3 words, ch2 holding 1 word, burst_len=4 -> ch0 x3 then ch2 x1; flash_wr_ch sequence 0,0,0,2.
REQ-026 flash_wr_ready held low for 5 cycles in XFER -> valid, data and addr held stable; exactly one fifo_rd pulse.
REQ-027 ADDR_LIMIT=ADDR_BASE+3, wrap_en=1, 6 words -> addresses 0,1,2,3,0,1; wrap pulses once.
REQ-028 Same window with wrap_en=0 -> 4 writes, then mem_full=1 and done; a following start gives done with no writes; addr_clr clears mem_full.
REQ-029 stop asserted during a burst of 8 -> current beat completes, then done; rst asserted mid-XFER -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared types for the DAQ flash logger: controller state encoding and
// the prio_mode values understood by the channel arbiter.
package daq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_XFER
    } state_e;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/daq_rr_arbiter.sv
// Combinational channel picker: round-robin starting after last_grant_i,
// or fixed priority where the lowest requesting index wins.
module daq_rr_arbiter
    import daq_pkg::*;
#(
    parameter int CH_COUNT = 4
) (
    input  logic [CH_COUNT-1:0]         req_i,
    input  logic [$clog2(CH_COUNT)-1:0] last_grant_i,
    input  logic                        mode_i,
    output logic [CH_COUNT-1:0]         gnt_o,
    output logic [$clog2(CH_COUNT)-1:0] idx_o
);

    localparam int IW = $clog2(CH_COUNT);

    int   cand;
    logic found;

    // Walk candidates in search order; the first requester seen wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (mode_i == PRIO_FIXED) begin
                cand = i;
            end else begin
                cand = (int'(last_grant_i) + 1 + i) % CH_COUNT;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/daq_flash_arbiter.sv
// Drains per-channel sensor FIFOs in bursts into a linear flash log window,
// one handshaken write per popped word.
module daq_flash_arbiter
    import daq_pkg::*;
#(
    parameter int                    CH_COUNT   = 4,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    BURST_MAX  = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           addr_clr,
    input  logic                           prio_mode,
    input  logic                           wrap_en,
    input  logic [$clog2(BURST_MAX+1)-1:0] burst_len,
    input  logic [CH_COUNT-1:0]            fifo_empty,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] fifo_data,
    output logic [CH_COUNT-1:0]            fifo_rd,
    output logic                           flash_wr_valid,
    input  logic                           flash_wr_ready,
    output logic [DATA_WIDTH-1:0]          flash_wr_data,
    output logic [ADDR_WIDTH-1:0]          flash_wr_addr,
    output logic [$clog2(CH_COUNT)-1:0]    flash_wr_ch,
    output logic                           busy,
    output logic                           done,
    output logic                           wrap,
    output logic                           mem_full
);

    localparam int BW = $clog2(BURST_MAX+1);
    localparam int IW = $clog2(CH_COUNT);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IW-1:0]         last_q, last_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [CH_COUNT-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  stop_q, stop_d;
    logic                  full_q, full_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;

    logic [CH_COUNT-1:0]   arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic [BW-1:0]         burst_eff;

    daq_rr_arbiter #(.CH_COUNT(CH_COUNT)) u_arb (
        .req_i        (~fifo_empty),
        .last_grant_i (last_q),
        .mode_i       (prio_mode),
        .gnt_o        (arb_gnt),
        .idx_o        (arb_idx)
    );

    always_comb begin
        if (burst_len == '0) begin
            burst_eff = BW'(1);
        end else if (burst_len > BW'(BURST_MAX)) begin
            burst_eff = BW'(BURST_MAX);
        end else begin
            burst_eff = burst_len;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        grant_d = grant_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        data_d  = data_q;
        stop_d  = stop_q;
        full_d  = full_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (state_q != ST_IDLE && stop) begin
            stop_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                // addr_clr is applied before start so a combined pulse restarts a full log.
                if (addr_clr) begin
                    addr_d = ADDR_BASE;
                    full_d = 1'b0;
                end
                if (start) begin
                    if (full_d) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                if (stop_d || (&fifo_empty)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else begin
                    grant_d = arb_idx;
                    gnt_d   = arb_gnt;
                    last_d  = arb_idx;
                    beat_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = fifo_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (flash_wr_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (addr_q == ADDR_LIMIT && !wrap_en) begin
                        full_d  = 1'b1;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        if (addr_q == ADDR_LIMIT) begin
                            addr_d = ADDR_BASE;
                            wrap_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                        // The empty flag here already reflects the pop issued in LOAD.
                        if (beat_d == burst_eff || fifo_empty[grant_q] || stop_d) begin
                            state_d = ST_ARB;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_BASE;
            last_q  <= IW'(CH_COUNT-1);
            grant_q <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            stop_q  <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            stop_q  <= stop_d;
            full_q  <= full_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign flash_wr_valid = (state_q == ST_XFER);
    assign fifo_rd        = (state_q == ST_LOAD) ? gnt_q : '0;
    assign flash_wr_data  = data_q;
    assign flash_wr_addr  = addr_q;
    assign flash_wr_ch    = grant_q;
    assign done           = done_q;
    assign wrap           = wrap_q;
    assign mem_full       = full_q;

endmodule

// File: tb/tb_daq_flash_arbiter.sv
// Directed bench for daq_flash_arbiter: a table of whole acquisitions plus
// hand sequences for stalls, stop, mem_full recovery and async reset.
module tb_daq_flash_arbiter;

    typedef struct packed {
        logic        useSmallWin;
        logic        prio;
        logic        wrapEn;
        logic [3:0]  burst;
        logic [15:0] words;
        logic [3:0]  nWr;
        logic [47:0] chSeq;
        logic [47:0] addrSeq;
        logic        expWrap;
        logic        expFull;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, addrClr = 1'b0;
    logic        prioMode = 1'b0, wrapEn = 1'b0, ready = 1'b1;
    logic [3:0]  burstLen = 4'd1;
    logic        useSmall = 1'b0;
    logic [3:0]  fifoEmpty;
    logic [63:0] fifoData;
    logic [3:0]  emptyA, emptyB;

    logic [3:0]  rdA, rdB, rdS;
    logic        validA, validB, validS;
    logic [15:0] dataA, dataB, dataS;
    logic [23:0] addrA, addrB, addrS;
    logic [1:0]  chA, chB, chS;
    logic        busyA, busyB, busyS, doneA, doneB, doneS;
    logic        wrapA, wrapB, wrapS, fullA, fullB, fullS;

    logic [15:0] fifoMem [4][16];
    int          fifoCnt [4];
    int          rdPtr [4];

    int          wrN, rdN, viol, doneN, wrapN;
    int          logCh [32];
    int          logAddr [32];
    int          logData [32];

    int          assertions = 0;
    int          failures = 0;
    int          curVec = 0;
    vec_t        vecs [8];

    always #5 clk = ~clk;

    daq_flash_arbiter dutA (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .addr_clr(addrClr),
        .prio_mode(prioMode), .wrap_en(wrapEn), .burst_len(burstLen),
        .fifo_empty(emptyA), .fifo_data(fifoData), .fifo_rd(rdA),
        .flash_wr_valid(validA), .flash_wr_ready(ready), .flash_wr_data(dataA),
        .flash_wr_addr(addrA), .flash_wr_ch(chA), .busy(busyA), .done(doneA),
        .wrap(wrapA), .mem_full(fullA)
    );

    daq_flash_arbiter #(.ADDR_LIMIT(24'd3)) dutB (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .addr_clr(addrClr),
        .prio_mode(prioMode), .wrap_en(wrapEn), .burst_len(burstLen),
        .fifo_empty(emptyB), .fifo_data(fifoData), .fifo_rd(rdB),
        .flash_wr_valid(validB), .flash_wr_ready(ready), .flash_wr_data(dataB),
        .flash_wr_addr(addrB), .flash_wr_ch(chB), .busy(busyB), .done(doneB),
        .wrap(wrapB), .mem_full(fullB)
    );

    // Only the selected instance sees real FIFOs; the other one sees all channels empty.
    always_comb begin
        emptyA = useSmall ? 4'hF : fifoEmpty;
        emptyB = useSmall ? fifoEmpty : 4'hF;
        rdS    = useSmall ? rdB : rdA;
        validS = useSmall ? validB : validA;
        dataS  = useSmall ? dataB : dataA;
        addrS  = useSmall ? addrB : addrA;
        chS    = useSmall ? chB : chA;
        busyS  = useSmall ? busyB : busyA;
        doneS  = useSmall ? doneB : doneA;
        wrapS  = useSmall ? wrapB : wrapA;
        fullS  = useSmall ? fullB : fullA;
    end

    // First-word-fall-through FIFO model; empty updates the cycle after a pop.
    always_comb begin
        fifoEmpty = '0;
        fifoData  = '0;
        for (int i = 0; i < 4; i++) begin
            fifoEmpty[i] = (rdPtr[i] >= fifoCnt[i]);
            fifoData[i*16 +: 16] = fifoMem[i][(rdPtr[i] < 16) ? rdPtr[i] : 15];
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rdPtr[i] <= 0;
            end else if (rdS[i]) begin
                rdPtr[i] <= rdPtr[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            wrN <= 0; rdN <= 0; viol <= 0; doneN <= 0; wrapN <= 0;
        end else begin
            if (validS && ready && wrN < 32) begin
                logCh[wrN]   <= int'(chS);
                logAddr[wrN] <= int'(addrS);
                logData[wrN] <= int'(dataS);
                wrN          <= wrN + 1;
            end
            if (rdS != 4'h0) begin
                rdN <= rdN + 1;
                if (((rdS & fifoEmpty) != 4'h0) || ($countones(rdS) != 1)) viol <= viol + 1;
            end
            if (doneS) doneN <= doneN + 1;
            if (wrapS) wrapN <= wrapN + 1;
        end
    end

    function automatic logic [15:0] mkData(input int ch, input int k);
        return 16'hA000 | 16'(ch << 8) | 16'(k);
    endfunction

    function automatic vec_t mkVec(input logic sm, input logic pr, input logic we,
                                   input logic [3:0] bl, input logic [15:0] w,
                                   input logic [3:0] n, input logic [47:0] cs,
                                   input logic [47:0] as, input logic ew, input logic ef);
        vec_t v;
        v.useSmallWin = sm; v.prio = pr; v.wrapEn = we; v.burst = bl; v.words = w;
        v.nWr = n; v.chSeq = cs; v.addrSeq = as; v.expWrap = ew; v.expFull = ef;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string name, input int idx, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL vec%0d %s[%0d]: got %0d, required %0d", curVec, name, idx, act, exp);
        end
    endtask

    task automatic waitDone(input int budget);
        int k = 0;
        while (doneS !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) checkEq("doneTimeout", k, 0, 1);
    endtask

    task automatic waitValid(input int budget);
        int k = 0;
        while (validS !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) checkEq("validTimeout", k, 0, 1);
    endtask

    task automatic loadFifos(input logic [15:0] w);
        for (int c = 0; c < 4; c++) begin
            fifoCnt[c] = int'(w[15-4*c -: 4]);
            for (int k = 0; k < 16; k++) fifoMem[c][k] = mkData(c, k);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = 1'b1;
        useSmall = v.useSmallWin;
        loadFifos(v.words);
        prioMode = v.prio; wrapEn = v.wrapEn; burstLen = v.burst;
        ready = 1'b1; start = 1'b0; stop = 1'b0; addrClr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(400);
        tick(); tick(); tick();
    endtask

    task automatic checkOutput(input vec_t v);
        int occ [4] = '{0, 0, 0, 0};
        int ch;
        checkEq("writes", 0, wrN, int'(v.nWr));
        for (int j = 0; j < int'(v.nWr) && j < wrN; j++) begin
            ch = int'(v.chSeq[47-4*j -: 4]);
            checkEq("ch", j, logCh[j], ch);
            checkEq("addr", j, logAddr[j], int'(v.addrSeq[47-4*j -: 4]));
            checkEq("data", j, logData[j], int'(mkData(ch, occ[ch])));
            occ[ch]++;
        end
        checkEq("rdPulses", 0, rdN, int'(v.nWr));
        checkEq("rdViolations", 0, viol, 0);
        checkEq("donePulses", 0, doneN, 1);
        checkEq("wrapPulses", 0, wrapN, int'(v.expWrap));
        checkEq("memFull", 0, int'(fullS), int'(v.expFull));
        checkEq("busyAfter", 0, int'(busyS), 0);
    endtask

    initial begin
        int base;
        vecs[0] = mkVec(0, 0, 1, 4'd1,  16'h2222, 4'd8,  48'h0123_0123_0000, 48'h0123_4567_0000, 0, 0);
        vecs[1] = mkVec(0, 1, 1, 4'd4,  16'h3010, 4'd4,  48'h0002_0000_0000, 48'h0123_0000_0000, 0, 0);
        vecs[2] = mkVec(0, 0, 1, 4'd0,  16'h2100, 4'd3,  48'h0100_0000_0000, 48'h0120_0000_0000, 0, 0);
        vecs[3] = mkVec(0, 0, 1, 4'd15, 16'hA001, 4'd11, 48'h0000_0000_3000, 48'h0123_4567_89A0, 0, 0);
        vecs[4] = mkVec(1, 0, 1, 4'd1,  16'h2211, 4'd6,  48'h0123_0100_0000, 48'h0123_0100_0000, 1, 0);
        vecs[5] = mkVec(0, 1, 1, 4'd2,  16'h1302, 4'd6,  48'h0111_3300_0000, 48'h0123_4500_0000, 0, 0);
        vecs[6] = mkVec(0, 0, 1, 4'd2,  16'h1302, 4'd6,  48'h0113_3100_0000, 48'h0123_4500_0000, 0, 0);
        vecs[7] = mkVec(1, 0, 0, 4'd1,  16'h2211, 4'd4,  48'h0123_0000_0000, 48'h0123_0000_0000, 0, 1);

        loadFifos(16'h0000);
        tick(); tick();
        checkEq("rstValid", 0, int'(validS), 0);
        checkEq("rstBusy", 0, int'(busyS), 0);
        checkEq("rstRd", 0, int'(rdS), 0);
        checkEq("rstAddr", 0, int'(addrS), 0);
        checkEq("rstFlags", 0, int'({doneS, wrapS, fullS}), 0);

        for (int i = 0; i < 8; i++) begin
            curVec = i;
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Window full: a plain start only pulses done, addr_clr+start restarts at the base.
        curVec = 8;
        base = wrN;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkEq("fullStartDone", 0, int'(doneS), 1);
        checkEq("fullStartBusy", 0, int'(busyS), 0);
        tick(); tick(); tick();
        checkEq("fullStartWrites", 0, wrN, base);
        addrClr = 1'b1; start = 1'b1;
        tick();
        addrClr = 1'b0; start = 1'b0;
        checkEq("clrStartFull", 0, int'(fullS), 0);
        checkEq("clrStartBusy", 0, int'(busyS), 1);
        waitDone(100);
        tick(); tick();
        checkEq("clrStartWrites", 0, wrN, base + 2);
        checkEq("clrStartAddr", 0, logAddr[base], 0);
        checkEq("clrStartAddr", 1, logAddr[base+1], 1);
        checkEq("clrStartCh", 0, logCh[base], 0);
        checkEq("clrStartCh", 1, logCh[base+1], 1);

        // Five-cycle stall on flash_wr_ready.
        curVec = 9;
        rst = 1'b1; useSmall = 1'b0; prioMode = 1'b0; burstLen = 4'd1; ready = 1'b0;
        loadFifos(16'h0100);
        tick(); tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(20);
        for (int c = 0; c < 5; c++) begin
            checkEq("stallValid", c, int'(validS), 1);
            checkEq("stallData", c, int'(dataS), int'(mkData(1, 0)));
            checkEq("stallAddr", c, int'(addrS), 0);
            checkEq("stallCh", c, int'(chS), 1);
            tick();
        end
        checkEq("stallRd", 0, rdN, 1);
        ready = 1'b1;
        waitDone(50);
        tick(); tick();
        checkEq("stallWrites", 0, wrN, 1);
        checkEq("stallRdEnd", 0, rdN, 1);

        // stop during a burst of 8: the pending beat finishes, then done.
        curVec = 10;
        rst = 1'b1; prioMode = 1'b1; burstLen = 4'd8; ready = 1'b0;
        loadFifos(16'h0080);
        tick(); tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ready = 1'b1;
        waitDone(50);
        tick(); tick();
        checkEq("stopWrites", 0, wrN, 1);
        checkEq("stopRd", 0, rdN, 1);
        checkEq("stopDone", 0, doneN, 1);
        checkEq("stopCh", 0, logCh[0], 2);

        // Asynchronous reset in the middle of a stalled beat.
        curVec = 11;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(20);
        checkEq("preRstValid", 0, int'(validS), 1);
        #2;
        rst = 1'b1;
        #1;
        checkEq("asyncValid", 0, int'(validS), 0);
        checkEq("asyncBusy", 0, int'(busyS), 0);
        checkEq("asyncRd", 0, int'(rdS), 0);
        checkEq("asyncData", 0, int'(dataS), 0);
        checkEq("asyncAddr", 0, int'(addrS), 0);
        checkEq("asyncCh", 0, int'(chS), 0);
        checkEq("asyncFlags", 0, int'({doneS, wrapS, fullS}), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
